// File: rtl/bitstream_word_packer.sv
// bitstream_word_packer
//   Packs an MSB-first byte stream into 32-bit configuration words, buffers
//   them in a small word FIFO and replays each one as a paced
//   SelfWriteData / SelfWriteStrobe transaction. SelfWriteData is stable for
//   SETUP_CYCLES before the one-cycle strobe and stays put until the next pop.
//   Optional feature macro: SYNC_DETECT_EN (hunt for SYNC_WORD before packing).
module bitstream_word_packer #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          SETUP_CYCLES = 2,
    parameter int          GAP_CYCLES   = 2,
    parameter logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        flush,
    output logic [31:0] SelfWriteData,
    output logic        SelfWriteStrobe,
    output logic        busy,
    output logic        synced,
    output logic [15:0] word_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    // Packer state
    logic [1:0]  k_q, k_d;
    logic [31:0] word_q, word_d;
    logic        push;
    logic [31:0] push_word;

    // Word FIFO (extra pointer bit distinguishes full from empty)
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full, pop;

    // Output sequencer
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic             strobe_q;

    logic accept, flush_ok;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign byte_ready = !fifo_full;
    assign accept     = byte_valid && byte_ready;
    assign flush_ok   = flush && byte_ready;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;

`ifdef SYNC_DETECT_EN
    logic [31:0] window_q, window_d;
    logic        synced_q, synced_d;
    assign synced = synced_q;
`else
    assign synced = 1'b1;
`endif

    logic [31:0] merged;
    logic [1:0]  k_next;

    // Byte packing (and header hunt when enabled): decide the next partial
    // word and whether a finished or flushed word enters the FIFO this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        k_d       = k_q;
        word_d    = word_q;
        push      = 1'b0;
        push_word = word_q;
        // A new word starts from zero so that flush padding is implicit.
        merged    = (k_q == 2'd0) ? 32'h0 : word_q;
        if (accept) begin
            case (k_q)
                2'd0:    merged[31:24] = byte_data;
                2'd1:    merged[23:16] = byte_data;
                2'd2:    merged[15:8]  = byte_data;
                default: merged[7:0]   = byte_data;
            endcase
        end
        k_next = accept ? k_q + 2'd1 : k_q;
`ifdef SYNC_DETECT_EN
        window_d = window_q;
        synced_d = synced_q;
        if (!synced_q) begin
            // Hunting: slide every accepted byte through the window; flush ignored.
            if (accept) begin
                window_d = {window_q[23:0], byte_data};
                if (window_d == SYNC_WORD) begin
                    push      = 1'b1;
                    push_word = SYNC_WORD;
                    synced_d  = 1'b1;
                    k_d       = 2'd0;
                end
            end
        end else begin
`endif
            word_d = merged;
            k_d    = k_next;
            if (accept && (k_q == 2'd3)) begin
                push      = 1'b1;
                push_word = merged;
            end else if (flush_ok && (k_next != 2'd0)) begin
                // Byte (if any) already merged; unused low bytes are zero.
                push      = 1'b1;
                push_word = merged;
                k_d       = 2'd0;
            end
`ifdef SYNC_DETECT_EN
        end
`endif
    end

    // Packer registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments only.
            k_q    <= 2'd0;
            word_q <= 32'h0;
`ifdef SYNC_DETECT_EN
            window_q <= 32'h0;
            synced_q <= 1'b0;
`endif
        end else begin
            k_q    <= k_d;
            word_q <= word_d;
`ifdef SYNC_DETECT_EN
            window_q <= window_d;
            synced_q <= synced_d;
`endif
        end
    end

    // FIFO storage
    always_ff @(posedge CLK) begin
        // NOTE: storage is not reset; the pointers alone define what is valid.
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_word;
    end

    // FIFO pointers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Output sequencer: pop, hold data for setup, strobe once, then back off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    data_d  = fifo_mem[rd_ptr_q[PTR_W-1:0]];
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) state_d = ST_STROBE;
                else                                    cnt_d   = cnt_q + 1'b1;
            end
            ST_STROBE: begin
                if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
                cnt_d   = '0;
                state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            default: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                                  cnt_d   = cnt_q + 1'b1;
            end
        endcase
    end

    // Sequencer registers; the strobe is registered so it is glitch-free.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= 32'h0;
            wcnt_q   <= 16'h0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            wcnt_q   <= wcnt_d;
            strobe_q <= (state_d == ST_STROBE);
        end
    end

    assign SelfWriteData   = data_q;
    assign SelfWriteStrobe = strobe_q;
    assign word_count      = wcnt_q;
    assign busy            = (k_q != 2'd0) || !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_bitstream_word_packer.sv
// Scoreboard bench for bitstream_word_packer: the driver feeds bytes and
// flushes, a byte-level reference model pushes expected words into a queue,
// and a monitor pops and compares on every SelfWriteStrobe.
module tb_bitstream_word_packer;

    localparam int          SETUP  = 2;
    localparam int          GAP    = 2;
    localparam int          PERIOD = 2 + SETUP + GAP;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
`ifdef SYNC_DETECT_EN
    localparam bit SYNC_BUILD = 1'b1;
`else
    localparam bit SYNC_BUILD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        resetn;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        flush;
    logic [31:0] SelfWriteData;
    logic        SelfWriteStrobe;
    logic        busy;
    logic        synced;
    logic [15:0] word_count;

    bitstream_word_packer dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .flush          (flush),
        .SelfWriteData  (SelfWriteData),
        .SelfWriteStrobe(SelfWriteStrobe),
        .busy           (busy),
        .synced         (synced),
        .word_count     (word_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model (byte level) ----------------
    logic [31:0] exp_q[$];
    logic [7:0]  m_part[$];
    logic [7:0]  m_win[$];
    bit          m_synced;
    int          m_pushed;

    function automatic void model_reset();
        exp_q.delete();
        m_part.delete();
        m_win.delete();
        m_synced = !SYNC_BUILD;
        m_pushed = 0;
    endfunction

    function automatic void model_emit(input logic [31:0] w);
        exp_q.push_back(w);
        m_pushed++;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_synced) begin
            m_win.push_back(b);
            if (m_win.size() > 4) void'(m_win.pop_front());
            if (m_win.size() == 4 && {m_win[0], m_win[1], m_win[2], m_win[3]} == SYNC) begin
                model_emit(SYNC);
                m_synced = 1'b1;
                m_part.delete();
            end
        end else begin
            m_part.push_back(b);
            if (m_part.size() == 4) begin
                model_emit({m_part[0], m_part[1], m_part[2], m_part[3]});
                m_part.delete();
            end
        end
    endfunction

    function automatic void model_flush();
        if (m_synced && m_part.size() > 0) begin
            while (m_part.size() < 4) m_part.push_back(8'h00);
            model_emit({m_part[0], m_part[1], m_part[2], m_part[3]});
            m_part.delete();
        end
    endfunction

    // ---------------- monitor ----------------
    int          mon_count = 0;
    bit          prev_strobe = 1'b0;
    logic [31:0] hist [SETUP];
    bit          spacing_on = 1'b0;
    bit          last_valid = 1'b0;
    int          last_cyc = 0;

    always @(negedge CLK) begin
        if (!resetn) begin
            mon_count   = 0;
            prev_strobe = 1'b0;
        end else begin
            if (SelfWriteStrobe) begin
                if (prev_strobe) fail_now("strobe_longer_than_one_cycle");
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_strobe: data %h with no word expected", SelfWriteData);
                end else begin
                    check("strobe_data", SelfWriteData, exp_q.pop_front());
                end
                for (int i = 0; i < SETUP; i++) check("data_stable_before_strobe", hist[i], SelfWriteData);
                check("word_count_at_strobe", {16'h0, word_count}, mon_count);
                mon_count++;
                if (spacing_on && last_valid) check("strobe_spacing", cyc - last_cyc, PERIOD);
                last_cyc   = cyc;
                last_valid = 1'b1;
            end
            if (prev_strobe) check("data_stable_after_strobe", SelfWriteData, hist[0]);
            prev_strobe = SelfWriteStrobe;
            for (int i = SETUP - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = SelfWriteData;
        end
    end

    // ---------------- driver ----------------
    int last_acc_cyc = 0;
    bit saw_not_ready = 1'b0;

    task automatic send_byte(input logic [7:0] b, input bit fl);
        bit done = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        flush      = fl;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge CLK);
            if (byte_ready) begin
                model_byte(b);
                if (fl) model_flush();
                last_acc_cyc = cyc;
                done = 1'b1;
            end else begin
                saw_not_ready = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        flush = 1'b0;
        if (!done) fail_now("byte_ready_timeout");
    endtask

    task automatic flush_pulse();
        byte_valid = 1'b0;
        flush      = 1'b1;
        @(negedge CLK);
        if (byte_ready) model_flush();
        @(posedge CLK);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        flush      = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_strobe(output int c);
        c = -1;
        for (int t = 0; t < 200 && c < 0; t++) begin
            @(negedge CLK);
            if (SelfWriteStrobe) c = cyc;
        end
        if (c < 0) fail_now("strobe_timeout");
    endtask

    task automatic drain();
        bit done = 1'b0;
        idle(0);
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
        check("word_count_after_drain", {16'h0, word_count}, m_pushed);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_header();
        if (SYNC_BUILD) begin
            send_byte(8'hFA, 1'b0);
            send_byte(8'hB0, 1'b0);
            send_byte(8'hFA, 1'b0);
            send_byte(8'hB1, 1'b0);
        end
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        flush      = 1'b0;
        resetn     = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // ---------------- directed and random sequences ----------------
    initial begin
        int s, s2, wc0;
        logic [7:0] hdr_seq [10];
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        flush      = 1'b0;
        resetn     = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_strobe", SelfWriteStrobe, 0);
        check("reset_data", SelfWriteData, 0);
        check("reset_word_count", word_count, 0);
        check("reset_busy", busy, 0);
        check("reset_byte_ready", byte_ready, 1);
        check("reset_synced", synced, !SYNC_BUILD);
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;

        // Header hunt: leading bytes at any alignment are dropped.
        if (SYNC_BUILD) begin
            hdr_seq = '{8'h00, 8'h11, 8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
            for (int i = 0; i < 10; i++) begin
                send_byte(hdr_seq[i], 1'b0);
                if (i == 4) check("synced_before_header", synced, 0);
                if (i == 5) check("synced_with_header", synced, 1);
            end
            check("model_header_words", exp_q.size() + mon_count, 2);
            drain();
        end

        // Single word and first-strobe latency.
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        idle(0);
        check("t1_expected_word", exp_q[exp_q.size()-1], 32'h1234_5678);
        wait_strobe(s);
        // Negedge before accept edge T to negedge of the strobe cycle: 1 + 3.
        check("t1_latency", s - last_acc_cyc, 4);
        drain();

        // 64 continuous bytes: FIFO fills, strobes back to back.
        saw_not_ready = 1'b0;
        last_valid    = 1'b0;
        spacing_on    = 1'b1;
        wc0           = word_count;
        for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0);
        drain();
        spacing_on = 1'b0;
        check("t2_byte_ready_dropped", saw_not_ready, 1);
        check("t2_strobes", word_count - wc0, 16);

        // Partial word flush, busy clears after the gap.
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        flush_pulse();
        check("t3_expected_word", exp_q[exp_q.size()-1], 32'hABCD_0000);
        wait_strobe(s);
        repeat (GAP) @(negedge CLK);
        check("t3_busy_in_gap", busy, 1);
        @(negedge CLK);
        check("t3_busy_after_gap", busy, 0);
        drain();

        // Reset in the strobe cycle with more words queued.
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1'b0);
        idle(0);
        wait_strobe(s);
        #2;
        resetn = 1'b0;
        #1;
        check("t4_strobe_drops", SelfWriteStrobe, 0);
        check("t4_word_count", word_count, 0);
        check("t4_busy", busy, 0);
        check("t4_byte_ready", byte_ready, 1);
        check("t4_synced", synced, !SYNC_BUILD);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        send_header();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        drain();

        // Randomised mix of bytes, gaps and flushes.
        for (int i = 0; i < 400; i++) begin
            s2 = $urandom_range(0, 9);
            if (s2 < 6)      send_byte(8'($urandom), $urandom_range(0, 7) == 0);
            else if (s2 < 9) idle(1);
            else             flush_pulse();
        end
        flush_pulse();
        drain();

        do_reset();
        check("final_reset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
